hanoi_move_sequencer: RTL

//  Generates the optimal 2^S-1 move sequence that transfers an S-disk tower from rod 0 to rod DST.

---
 rtl/hanoi_move_sequencer_if.sv | 10 +
 rtl/hanoi_move_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/hanoi_move_sequencer_if.sv
// hanoi_move_sequencer_if: move handshake from the sequencer to the rod datapath.
interface hanoi_move_sequencer_if #(parameter int DW = 2);
   logic          mv_valid;
   logic          mv_ready;
   logic [1:0]    mv_fr;
   logic [1:0]    mv_to;
   logic [DW-1:0] mv_disk;
   modport master (output mv_valid, mv_fr, mv_to, mv_disk, input mv_ready);
   modport slave (input mv_valid, mv_fr, mv_to, mv_disk, output mv_ready);
endinterface

// File: rtl/hanoi_move_sequencer.sv
// hanoi_move_sequencer: issues the optimal 2^S-1 moves taking an S-disk tower from rod 0 to rod DST.
// Optional legality checker with err port: HANOI_LEGAL_CHK_EN.
module hanoi_move_sequencer #(
   parameter int S = 4,
   parameter int DST = 2,
   localparam int DW = (S > 1) ? $clog2(S) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic [S-1:0] mv_cnt,
`ifdef HANOI_LEGAL_CHK_EN
   output logic         err,
`endif
   hanoi_move_sequencer_if.master mv
);
   if (DST != 1 && DST != 2) begin : g_bad_dst
      $error("hanoi_move_sequencer: DST must be 1 or 2");
   end
   if (S < 1 || S > 15) begin : g_bad_s
      $error("hanoi_move_sequencer: S must be 1..15");
   end
   typedef enum logic [1:0] {IDLE, CALC, ISSUE, DONE} state_t;
   // disk 0 steps 0->1->2 when the parity of S and DST call for it, otherwise 0->2->1
   localparam bit CW = ((S % 2 == 0) && DST == 2) || ((S % 2 == 1) && DST == 1);
   localparam logic [2:0][S-1:0] ROD_INIT = {{S{1'b0}}, {S{1'b0}}, {S{1'b1}}};
   state_t state_q, state_d;
   logic [2:0][S-1:0] rod_q, rod_d;
   logic [S-1:0] cnt_q, cnt_d;
   logic [1:0] fr_q, fr_d, to_q, to_d;
   logic [DW-1:0] disk_q, disk_d;
   logic busy_q, busy_d, done_q, done_d, valid_q, valid_d;
   logic [1:0] p, pn, pp;
   logic [DW-1:0] top_n, top_p;
   logic a_to_b;
`ifdef HANOI_LEGAL_CHK_EN
   logic err_q, err_d;
`endif
   function automatic logic [DW-1:0] top_idx(input logic [S-1:0] m);
      top_idx = '0;
      for (int i = S - 1; i >= 0; i--) if (m[i]) top_idx = DW'(i);
   endfunction
   always_comb begin
      p = rod_q[1][0] ? 2'd1 : rod_q[2][0] ? 2'd2 : 2'd0;
      pn = (p == 2'd2) ? 2'd0 : p + 2'd1;
      pp = (p == 2'd0) ? 2'd2 : p - 2'd1;
      top_n = top_idx(rod_q[pn]);
      top_p = top_idx(rod_q[pp]);
      a_to_b = (rod_q[pn] != '0) && ((rod_q[pp] == '0) || (top_n < top_p));
      state_d = state_q;
      rod_d = rod_q;
      cnt_d = cnt_q;
      fr_d = fr_q;
      to_d = to_q;
      disk_d = disk_q;
`ifdef HANOI_LEGAL_CHK_EN
      err_d = err_q;
`endif
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d = CALC;
            rod_d = ROD_INIT;
            cnt_d = '0;
         end
         CALC: begin
            fr_d = cnt_q[0] ? (a_to_b ? pn : pp) : p;
            to_d = cnt_q[0] ? (a_to_b ? pp : pn) : (CW ? pn : pp);
            disk_d = cnt_q[0] ? (a_to_b ? top_n : top_p) : '0;
            state_d = ISSUE;
`ifdef HANOI_LEGAL_CHK_EN
            if (rod_q[fr_d] == '0 || (rod_q[to_d] != '0 && top_idx(rod_q[to_d]) < disk_d)) begin
               err_d = 1'b1;
               state_d = DONE;
            end
`endif
         end
         ISSUE: if (mv.mv_ready) begin
            rod_d[fr_q] = rod_q[fr_q] & ~(S'(1) << disk_q);
            rod_d[to_q] = rod_q[to_q] | (S'(1) << disk_q);
            cnt_d = cnt_q + S'(1);
            state_d = (cnt_d == '1) ? DONE : CALC;
         end
         default: ;
      endcase
      busy_d = (state_d == CALC) || (state_d == ISSUE);
      done_d = state_d == DONE;
      valid_d = state_d == ISSUE;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         rod_q <= ROD_INIT;
         cnt_q <= '0;
         fr_q <= '0;
         to_q <= '0;
         disk_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         valid_q <= 1'b0;
`ifdef HANOI_LEGAL_CHK_EN
         err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rod_q <= rod_d;
         cnt_q <= cnt_d;
         fr_q <= fr_d;
         to_q <= to_d;
         disk_q <= disk_d;
         busy_q <= busy_d;
         done_q <= done_d;
         valid_q <= valid_d;
`ifdef HANOI_LEGAL_CHK_EN
         err_q <= err_d;
`endif
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign mv_cnt = cnt_q;
   assign mv.mv_valid = valid_q;
   assign mv.mv_fr = fr_q;
   assign mv.mv_to = to_q;
   assign mv.mv_disk = disk_q;
`ifdef HANOI_LEGAL_CHK_EN
   assign err = err_q;
`endif
endmodule
